// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronised rx, mid-bit start check, LSB-first data.
// Define UART_RX_PARITY_EN to add one parity bit per frame (odd when PARITY_ODD=1).
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] MID_CNT  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
    $error("uart_rx: illegal parameter value");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t               state;
  state_t               state_next;
  logic                 rx_meta;
  logic                 rx_sync;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 shift_en;
  logic                 stop_en;
`ifdef UART_RX_PARITY_EN
  localparam logic ODD = (PARITY_ODD != 0);
  logic                 parity_en;
  logic                 parity_bad;
`endif

  // Synchroniser flops reset to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state) begin
        cnt <= '0;
      end else if (sample_tick) begin
        cnt <= (cnt == LAST_CNT) ? '0 : cnt + CW'(1);
      end
      if (state != DATA) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    stop_en    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_en  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (sample_tick && !rx_sync) state_next = START;
      end
      START: begin
        if (sample_tick && cnt == MID_CNT) state_next = rx_sync ? IDLE : DATA;
      end
      DATA: begin
        if (sample_tick && cnt == LAST_CNT) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample_tick && cnt == LAST_CNT) begin
          parity_en  = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (sample_tick && cnt == LAST_CNT) begin
          stop_en    = 1'b1;
          state_next = rx_sync ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (sample_tick && rx_sync) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Data shifts in from the top so the first (LSB) bit ends up in bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid <= stop_en;
      if (shift_en) shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
      if (stop_en) begin
        rx_data   <= shift_reg;
        frame_err <= ~rx_sync;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_bad <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (parity_en) parity_bad <= rx_sync ^ (^shift_reg) ^ ODD;
      if (stop_en) parity_err <= parity_bad;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, hand-written corner sequences and random frames.
// Build with UART_RX_PARITY_EN defined to exercise the odd-parity variant.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int TICK_DIV   = 3;
  localparam int BIT_CLKS   = OVERSAMPLE * TICK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN     = 1'b1;
  localparam int PARITY_ODD = 1;
`else
  localparam bit PAR_EN     = 1'b0;
  localparam int PARITY_ODD = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_tick;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } rec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par_bit;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr_par;
  } vec_t;

  rec_t obs_q[$];
  rec_t exp_q[$];
  vec_t vecs[6];
  int   total = 0;
  int   bad = 0;
  logic prev_valid = 1'b0;
  logic busy_seen = 1'b0;

  uart_rx #(
    .DATA_BITS(DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sample_tick(sample_tick),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (busy) busy_seen = 1'b1;
    if (rx_valid) begin
      obs_q.push_back(rec_t'({rx_data, frame_err, parity_err}));
      checkOutput("rx_valid_single_pulse", {31'd0, prev_valid}, 32'd0);
    end
    prev_valid = rx_valid;
  end

  function automatic logic goodPar(input logic [7:0] data);
    return logic'(($countones(data) + PARITY_ODD) % 2);
  endfunction

  function automatic rec_t modelFrame(input logic [7:0] data, input logic stop, input logic par_bit);
    rec_t r;
    r.data = data;
    r.ferr = ~stop;
    r.perr = PAR_EN && (par_bit != goodPar(data));
    return r;
  endfunction

  // Drives one frame; gap_bits=0 leaves rx at the stop level for an immediate next frame.
  task automatic applyStimulus(input logic [7:0] data, input logic stop, input logic par_bit, input int gap_bits);
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx = data[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (PAR_EN) begin
      rx = par_bit;
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = stop;
    repeat (BIT_CLKS) @(negedge clk);
    if (gap_bits > 0) begin
      rx = 1'b1;
      repeat (gap_bits * BIT_CLKS) @(negedge clk);
    end
  endtask

  task automatic waitObs(input int n, input string name);
    int waited = 0;
    while (obs_q.size() < n && waited < 4 * BIT_CLKS) begin
      @(negedge clk);
      waited++;
    end
    checkOutput(name, obs_q.size(), n);
  endtask

  task automatic checkRec(input string name, input int idx, input rec_t exp_rec);
    logic [31:0] act;
    act = (idx < obs_q.size()) ? {22'd0, obs_q[idx]} : 32'hFFFF_FFFF;
    checkOutput(name, act, {22'd0, exp_rec});
  endtask

  initial begin
    rx  = 1'b1;
    rst = 1'b1;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 1, 8'h01, 1'b0, 1'b1};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 1, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b1, 2, 8'h3C, 1'b1, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 1, 8'h00, 1'b0, 1'b1};

    repeat (5) @(negedge clk);
    checkOutput("reset_rx_data", {24'd0, rx_data}, 32'd0);
    checkOutput("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("reset_parity_err", {31'd0, parity_err}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);

    // Release reset right before a tick so a wrongly reset synchroniser would start a frame.
    do begin
      @(negedge clk);
      #1;
    end while (!sample_tick);
    rst = 1'b0;
    busy_seen = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    checkOutput("idle_after_reset", {31'd0, busy_seen}, 32'd0);

    foreach (vecs[k]) begin
      rec_t e;
      obs_q.delete();
      applyStimulus(vecs[k].data, vecs[k].stop, vecs[k].par_bit, vecs[k].gap);
      waitObs(1, "vec_count");
      e.data = vecs[k].exp_data;
      e.ferr = vecs[k].exp_ferr;
      e.perr = PAR_EN ? vecs[k].exp_perr_par : 1'b0;
      checkRec("vec_frame", 0, e);
      checkOutput("vec_busy_after", {31'd0, busy}, 32'd0);
    end

    obs_q.delete();
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (4 * TICK_DIV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    checkOutput("glitch_no_valid", obs_q.size(), 32'd0);
    checkOutput("glitch_entered_start", {31'd0, busy_seen}, 32'd1);
    checkOutput("glitch_back_idle", {31'd0, busy}, 32'd0);

    obs_q.delete();
    applyStimulus(8'h3C, 1'b0, goodPar(8'h3C), 0);
    repeat (40 * TICK_DIV) @(negedge clk);
    waitObs(1, "break_count");
    checkRec("break_frame", 0, rec_t'({8'h3C, 1'b1, 1'b0}));
    checkOutput("break_busy_held", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    repeat (3 * TICK_DIV + 4) @(negedge clk);
    checkOutput("break_busy_released", {31'd0, busy}, 32'd0);

    obs_q.delete();
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_valid", {31'd0, rx_valid}, 32'd0);
    repeat (10 * BIT_CLKS) @(negedge clk);
    checkOutput("midreset_no_frame", obs_q.size(), 32'd0);
    applyStimulus(8'h3C, 1'b1, goodPar(8'h3C), 1);
    waitObs(1, "after_reset_count");
    checkRec("after_reset_frame", 0, modelFrame(8'h3C, 1'b1, goodPar(8'h3C)));

    obs_q.delete();
    applyStimulus(8'h00, 1'b1, goodPar(8'h00), 0);
    applyStimulus(8'hFF, 1'b1, goodPar(8'hFF), 1);
    waitObs(2, "b2b_count");
    checkRec("b2b_first", 0, rec_t'({8'h00, 1'b0, 1'b0}));
    checkRec("b2b_second", 1, rec_t'({8'hFF, 1'b0, 1'b0}));

    obs_q.delete();
    exp_q.delete();
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      logic       s;
      logic       p;
      int         g;
      d = 8'($urandom_range(0, 255));
      s = ($urandom_range(0, 4) != 0);
      p = ($urandom_range(0, 1) != 0) ? goodPar(d) : ~goodPar(d);
      g = s ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      exp_q.push_back(modelFrame(d, s, p));
      applyStimulus(d, s, p, g);
    end
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    waitObs(exp_q.size(), "random_count");
    foreach (exp_q[i]) checkRec("random_frame", i, exp_q[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
